// File: rtl/rf_port_arbiter.sv
// Shares the single register-file port between the CPU controller and a debug/test port.
// Each grant lasts one cycle, the CPU wins ties, and cpu_lock keeps debug out of multi-stage instructions.
module rf_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_lock_i,
    output logic              cpu_gnt_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              dbg_rvalid_o,
    output logic              rf_en_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [7:0]        dbg_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_DBG  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
    logic              cpu_rvalid_q, dbg_rvalid_q;
    logic [7:0]        dbg_count_q;
    logic              cpu_cand_s, dbg_cand_s;

    // Next grant: a requester just served cannot win again, CPU beats debug, lock blocks debug.
    always_comb begin
        cpu_cand_s = cpu_req_i && (state_q != S_CPU);
        dbg_cand_s = dbg_req_i && (state_q != S_DBG) && !cpu_lock_i;
        if (cpu_cand_s) begin
            state_d = S_CPU;
        end else if (dbg_cand_s) begin
            state_d = S_DBG;
        end else begin
            state_d = S_IDLE;
        end
    end

    // Grant state, read-data capture at the end of a read grant, and debug access counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cpu_rdata_q  <= {DATA_W{1'b0}};
            dbg_rdata_q  <= {DATA_W{1'b0}};
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            case (state_q)
                S_CPU: begin
                    if (!cpu_we_i) begin
                        cpu_rdata_q  <= rf_rdata_i;
                        cpu_rvalid_q <= 1'b1;
                    end
                end
                S_DBG: begin
                    if (!dbg_we_i) begin
                        dbg_rdata_q  <= rf_rdata_i;
                        dbg_rvalid_q <= 1'b1;
                    end
                    dbg_count_q <= dbg_count_q + 8'd1;
                end
                default: begin
                    dbg_count_q <= dbg_count_q;
                end
            endcase
        end
    end

    // Port mux is a pure decode of the registered grant; the idle port is driven to zero.
    always_comb begin
        rf_en_o    = 1'b0;
        rf_we_o    = 1'b0;
        rf_addr_o  = {ADDR_W{1'b0}};
        rf_wdata_o = {DATA_W{1'b0}};
        case (state_q)
            S_CPU: begin
                rf_en_o    = 1'b1;
                rf_we_o    = cpu_we_i;
                rf_addr_o  = cpu_addr_i;
                rf_wdata_o = cpu_wdata_i;
            end
            S_DBG: begin
                rf_en_o    = 1'b1;
                rf_we_o    = dbg_we_i;
                rf_addr_o  = dbg_addr_i;
                rf_wdata_o = dbg_wdata_i;
            end
            default: begin
                rf_en_o = 1'b0;
            end
        endcase
    end

    assign cpu_gnt_o    = (state_q == S_CPU);
    assign dbg_gnt_o    = (state_q == S_DBG);
    assign cpu_rdata_o  = cpu_rdata_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign dbg_count_o  = dbg_count_q;

endmodule

// File: doc/rf_port_arbiter.md
# rf_port_arbiter

Single-clock arbiter sharing the 16-entry register file between two requesters: the CPU controller (LoadReg/DumpReg traffic) and a debug/test port used by the bench or a host loader. It multiplexes address, write data and write enable onto the register file's one port, registers read data back to whichever requester owned the access, and honours a CPU lock so multi-stage instructions are never interleaved with debug accesses. It sits between the controller/accumulator side of the datapath and the register file.

## Interface
- DATA_W, 8, register data width
- ADDR_W, 4, register index width (16 registers)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU requests one register access
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  register index
- cpu_wdata  in  DATA_W  write data
- cpu_lock  in  1  while high, debug port is never granted
- cpu_gnt  out  1  CPU owns the port this cycle
- cpu_rdata  out  DATA_W  last read data returned to CPU
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata updated
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug equivalents
- dbg_gnt, dbg_rdata, dbg_rvalid  out  1/DATA_W/1  debug equivalents
- rf_en  out  1  register file access this cycle
- rf_we  out  1  register file write strobe
- rf_addr  out  ADDR_W  register file index
- rf_wdata  out  DATA_W  register file write data
- rf_rdata  in  DATA_W  register file combinational read data for rf_addr
- dbg_count  out  8  number of completed debug accesses, wraps 255 -> 0

## Operation
- FSM, registered state S ∈ {IDLE, CPU, DBG}; cpu_gnt = (S==CPU), dbg_gnt = (S==DBG), both registered, never both high.
- Next state computed each cycle from current S and inputs:
  - cpu_cand = cpu_req && S!=CPU
  - dbg_cand = dbg_req && S!=DBG && !cpu_lock
  - cpu_cand -> CPU; else dbg_cand -> DBG; else IDLE.
- Consequences: every grant lasts exactly one cycle; a requester is never granted two consecutive cycles; with both requesting continuously and lock low, grants alternate CPU, DBG, CPU, ...; CPU wins all ties.
- Requester protocol: hold req, we, addr, wdata stable from req assertion through the cycle its gnt is high. The access transfers in the gnt cycle. req seen in the cycle after gnt is a new request.
- Port mux: in a gnt cycle, rf_en=1, rf_we/rf_addr/rf_wdata = granted requester's we/addr/wdata. In IDLE, rf_en=0, rf_we=0, rf_addr=0, rf_wdata=0.
- Read return: on a read grant, rf_rdata is captured at the end of the gnt cycle into that requester's rdata; its rvalid pulses high the following cycle. rdata holds until the next read by the same requester. Writes produce no rvalid.
- dbg_count increments at the end of each DBG cycle (read or write), 8-bit wrap.
- cpu_lock is sampled only in the next-state decision; a DBG grant already registered completes even if lock rises in that cycle.

## Timing
- Reset (synchronous): S=IDLE, both gnt=0, both rvalid=0, both rdata=0, dbg_count=0, rf_en=0, rf_we=0, rf_addr=0, rf_wdata=0. Reset in a gnt cycle aborts that access: rf_we forced 0 that cycle is not required (outputs are registered/decoded from S), but no rvalid, no dbg_count increment follow.
- Latency: req high at cycle N (port idle) -> gnt at N+1 -> rvalid and rdata at N+2.
- Write at gnt cycle N is visible to a read granted at N+1 by the other requester.
- Peak throughput: 1 access/cycle aggregate, 1 access per 2 cycles per requester.
- Lock: dbg_req held while cpu_lock high -> no dbg_gnt; first dbg_gnt at earliest one cycle after lock falls (subject to CPU priority).

## Test plan
- Reset, then CPU write addr 3 data 0x5A (req at cycle 1) -> cpu_gnt cycle 2 with rf_we=1, rf_addr=3, rf_wdata=0x5A; no cpu_rvalid; all outputs 0 during reset.
- Debug read addr 3 after above -> dbg_gnt at N+1, dbg_rvalid pulse at N+2 with dbg_rdata=0x5A, dbg_count=1.
- Both req held continuously 6 cycles, lock low -> grants CPU, DBG, CPU, DBG, CPU, DBG; never both gnt; no requester granted twice in a row.
- cpu_lock high 5 cycles with dbg_req held and cpu_req idle -> no dbg_gnt; lock falls at cycle L -> dbg_gnt at L+1.
- 256 debug writes -> dbg_count wraps to 0.
- Assert reset during a CPU read gnt cycle -> next cycle S=IDLE, cpu_rvalid=0, cpu_rdata=0.
